// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one single-port cache between
// NUM_REQ requesters, with a sticky watchdog for stalled transactions.
//
// Ports:
//   clk, rst_l                     clock, async active-low reset
//   req_valid/write/through        per-requester request bits
//   req_addr, req_wdata            per-requester address / store data
//   req_ack, req_rdata             one-hot completion pulse, load data
//   w_en, r_en                     cache enables
//   write_through, read_through    cache bypass selects
//   addr, data_store               cache address / store data
//   data_load, done                cache load data / completion
//   busy, timeout_err              in-flight flag, sticky watchdog flag
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module cache_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `ADDR_SIZE,
  parameter int TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_through,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0]       req_wdata,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [31:0]                    req_rdata,
  output logic                           w_en,
  output logic                           r_en,
  output logic                           write_through,
  output logic                           read_through,
  output logic [ADDR_W-1:0]              addr,
  output logic [31:0]                    data_store,
  input  logic [31:0]                    data_load,
  input  logic                           done,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CAPTURE,
    RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic              wr_q, wr_d;
  logic              thr_q, thr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;

  logic [NUM_REQ-1:0] ack_vec;
  logic [NUM_REQ-1:0] cand;
  logic               pick_ok;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   pick_nxt;
  logic               active;
  int                 sidx;

  always_comb begin
    ack_vec        = '0;
    ack_vec[win_q] = 1'b1;
  end

  // The just-acked requester may still hold valid during RELEASE.
  assign cand = (state_q == RELEASE) ? (req_valid & ~ack_vec)
                                     : req_valid;

  // Search upward from rr_q with wrap-around.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    sidx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sidx = int'(rr_q) + i;
      if (sidx >= NUM_REQ) sidx = sidx - NUM_REQ;
      if (!pick_ok && cand[IDX_W'(sidx)]) begin
        pick_ok = 1'b1;
        pick    = IDX_W'(sidx);
      end
    end
    if (int'(pick) == NUM_REQ - 1) pick_nxt = '0;
    else                           pick_nxt = pick + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    thr_d   = thr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wd_d    = wd_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
      end
      GRANT: begin
        wd_d = wd_q + 1'b1;
        if (done) begin
          state_d = CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          rdata_d = '0;
          state_d = RELEASE;
        end
      end
      CAPTURE: begin
        rdata_d = wr_q ? 32'd0 : data_load;
        state_d = RELEASE;
      end
      RELEASE: begin
        wd_d    = '0;
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE || state_q == RELEASE) && pick_ok) begin
      state_d = GRANT;
      win_d   = pick;
      rr_d    = pick_nxt;
      wr_d    = req_write[pick];
      thr_d   = req_through[pick];
      addr_d  = req_addr[pick];
      wdata_d = req_wdata[pick];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      thr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      thr_q   <= thr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign active        = (state_q == GRANT) ||
                         (state_q == CAPTURE);
  assign w_en          = active & wr_q;
  assign r_en          = active & ~wr_q;
  assign write_through = w_en & thr_q;
  assign read_through  = r_en & thr_q;
  assign addr          = active ? addr_q : '0;
  assign data_store    = w_en ? wdata_q : '0;
  assign req_ack       = (state_q == RELEASE) ? ack_vec : '0;
  assign req_rdata     = rdata_q;
  assign busy          = active;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter
// with a small behavioural single-port cache model.
module tb_cache_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst_l = 1'b0;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_write;
  logic [N-1:0]           req_through;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][31:0]     req_wdata;
  logic [N-1:0]           req_ack;
  logic [31:0]            req_rdata;
  logic                   w_en, r_en;
  logic                   write_through, read_through;
  logic [AW-1:0]          addr;
  logic [31:0]            data_store;
  logic [31:0]            data_load;
  logic                   done;
  logic                   busy, timeout_err;

  int checks = 0;
  int failures = 0;
  int dly = 1;
  logic hang = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_write(req_write),
    .req_through(req_through), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack),
    .req_rdata(req_rdata), .w_en(w_en), .r_en(r_en),
    .write_through(write_through),
    .read_through(read_through), .addr(addr),
    .data_store(data_store), .data_load(data_load),
    .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  // Cache model: done rises dly cycles after the enable rises,
  // holds while enabled; load data lands one cycle after done.
  logic [31:0]  mem [0:255];
  logic [255:0] wr_vld;
  int           cnt;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      done      <= 1'b0;
      cnt       <= 0;
      data_load <= '0;
      wr_vld    <= '0;
    end else if (w_en || r_en) begin
      if (!done) begin
        if (!hang && cnt == dly - 1) done <= 1'b1;
        cnt <= cnt + 1;
      end else begin
        if (w_en) begin
          mem[addr[7:0]]    <= data_store;
          wr_vld[addr[7:0]] <= 1'b1;
        end
        if (r_en)
          data_load <= wr_vld[addr[7:0]] ? mem[addr[7:0]]
                                         : {16'hC0DE, addr};
      end
    end else begin
      done <= 1'b0;
      cnt  <= 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int who,
                          output int n, output int wc,
                          output int rc, output int te,
                          output logic [31:0] rd);
    n = 0; wc = 0; rc = 0; te = 0; rd = '0;
    while (n < 60) begin
      tick();
      n++;
      wc += int'(w_en);
      rc += int'(r_en);
      if (te == 0 && timeout_err) te = n;
      if (req_ack != '0) break;
    end
    chk("ack_vec", 32'(req_ack), 32'(1) << who);
    rd = req_rdata;
  endtask

  int n, wc, rc, te, both, nack, cyc, idx;
  logic [31:0] rd;
  logic prev_ack;
  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    req_valid   = '0;
    req_write   = '0;
    req_through = '0;
    req_addr    = '0;
    req_wdata   = '0;
    tick();
    tick();
    chk("rst_en", {30'd0, w_en, r_en}, 32'd0);
    chk("rst_thr", {30'd0, write_through, read_through}, 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_busy_to", {30'd0, busy, timeout_err}, 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_rdata", req_rdata, 32'd0);
    chk("rst_dstore", data_store, 32'd0);
    rst_l = 1'b1;
    tick();

    // single store, done after 3 enabled cycles
    dly          = 2;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 16'h0010;
    req_wdata[0] = 32'hDEADBEEF;
    wait_ack(0, n, wc, rc, te, rd);
    chk("st_latency", 32'(n), 32'd5);
    chk("st_wen_cycles", 32'(wc), 32'd4);
    chk("st_ren_cycles", 32'(rc), 32'd0);
    req_valid = '0;
    req_write = '0;
    tick();
    chk("st_ack_pulse", 32'(req_ack), 32'd0);
    chk("st_idle", 32'(busy), 32'd0);

    // single load of the stored word
    dly          = 3;
    req_valid[2] = 1'b1;
    req_addr[2]  = 16'h0010;
    wait_ack(2, n, wc, rc, te, rd);
    chk("ld_latency", 32'(n), 32'd6);
    chk("ld_ren_cycles", 32'(rc), 32'd5);
    chk("ld_wen_cycles", 32'(wc), 32'd0);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    req_valid = '0;
    tick();

    // contention: all valid from reset
    rst_l = 1'b0;
    dly   = 1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_addr[i]  = 16'(16'h0020 + i);
    end
    tick();
    rst_l    = 1'b1;
    both     = 0;
    nack     = 0;
    cyc      = 0;
    prev_ack = 1'b0;
    while (nack < 5 && cyc < 80) begin
      tick();
      cyc++;
      if (w_en && r_en) both++;
      if (prev_ack) chk("rr_no_gap", 32'(w_en | r_en), 32'd1);
      prev_ack = 1'b0;
      if (req_ack != '0) begin
        idx = 0;
        for (int b = 0; b < N; b++)
          if (req_ack[b]) idx = b;
        chk("rr_dead_cycle", 32'(w_en | r_en), 32'd0);
        chk("rr_onehot", 32'($countones(req_ack)), 32'd1);
        chk("rr_rdata", req_rdata,
            {16'hC0DE, 16'(16'h0020 + idx)});
        order[nack] = idx;
        nack++;
        prev_ack = 1'b1;
        if (nack == 5) req_valid = '0;
      end
    end
    chk("rr_count", 32'(nack), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("rr_order", 32'(order[k]), 32'(exp_order[k]));
    chk("rr_dual_en", 32'(both), 32'd0);
    tick();
    chk("rr_idle", 32'(busy), 32'd0);

    // stale valid held through the ack cycle
    req_valid[1] = 1'b1;
    req_addr[1]  = 16'h0030;
    wait_ack(1, n, wc, rc, te, rd);
    chk("stale_latency", 32'(n), 32'd4);
    tick();
    chk("stale_no_regrant", 32'(busy), 32'd0);
    req_valid[1] = 1'b0;
    tick();
    chk("stale_still_idle", 32'(busy | r_en), 32'd0);
    req_valid[1] = 1'b1;
    tick();
    chk("fresh_regrant", 32'(r_en), 32'd1);
    wait_ack(1, n, wc, rc, te, rd);
    chk("fresh_rdata", rd, 32'hC0DE0030);
    req_valid = '0;
    tick();

    // read-through with address churn mid-transaction
    dly            = 2;
    req_valid[3]   = 1'b1;
    req_through[3] = 1'b1;
    req_addr[3]    = 16'h0040;
    tick();
    chk("thr_en", {30'd0, w_en, r_en}, 32'd1);
    chk("thr_sel", {30'd0, write_through, read_through},
        32'd1);
    chk("thr_addr", 32'(addr), 32'h40);
    req_addr[3] = 16'h0099;
    tick();
    chk("thr_addr_hold", 32'(addr), 32'h40);
    wait_ack(3, n, wc, rc, te, rd);
    chk("thr_rdata", rd, 32'hC0DE0040);
    req_valid   = '0;
    req_through = '0;
    tick();

    // watchdog: done never comes
    hang         = 1'b1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 16'h0050;
    wait_ack(0, n, wc, rc, te, rd);
    chk("wd_ack_cycle", 32'(n), 32'(TO + 1));
    chk("wd_err_cycle", 32'(te), 32'(TO + 1));
    chk("wd_rdata", rd, 32'd0);
    req_valid = '0;
    tick();
    tick();
    chk("wd_sticky", 32'(timeout_err), 32'd1);

    // async reset while granted
    req_valid[1] = 1'b1;
    req_addr[1]  = 16'h0060;
    tick();
    chk("pre_rst_grant", 32'(r_en), 32'd1);
    #3;
    rst_l = 1'b0;
    #1;
    chk("async_rst_en", {30'd0, w_en, r_en}, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_err", 32'(timeout_err), 32'd0);
    req_valid = '0;
    hang      = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single-port cache between NUM_REQ requesters, e.g. compute lanes and a DMA/loader.
- Uses round-robin arbitration. Each granted request is latched and sequenced through the cache's level-enable / done handshake, and read data is returned with a one-cycle ack pulse.
- Includes a watchdog that flags a cache transaction that never completes.
- Sits between the requesters and the cache; drives the cache's w_en / r_en / write_through / read_through / addr / data_store.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, `ADDR_SIZE, cache address width.
- TIMEOUT, 1024, cycles from grant to cache done before the watchdog fires.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request; held with fields stable until req_ack.
- req_write  in  NUM_REQ  1=store, 0=load.
- req_through  in  NUM_REQ  1=bypass (write_through/read_through).
- req_addr  in  NUM_REQ x ADDR_W  request addresses.
- req_wdata  in  NUM_REQ x 32  store data.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_rdata  out  32  load data, valid while any req_ack bit is high.
- w_en, r_en  out  1  cache enables.
- write_through, read_through  out  1  cache bypass selects.
- addr  out  ADDR_W  cache address.
- data_store  out  32  cache store data.
- data_load  in  32  cache load data.
- done  in  1  cache completion.
- busy  out  1  high in GRANT/CAPTURE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset:
  - All outputs are 0. State is IDLE and rr_ptr is 0.
  - The watchdog counter is 0 and timeout_err is cleared; reset is the only way to clear it.
  - Reset mid-transaction drops the enables immediately (the cache shares rst_l).
- Cache handshake, fixed by the cache:
  - w_en/r_en must be held until done rises.
  - done stays high while the enable stays high.
  - Read data is registered: data_load is valid one cycle after done first rises.
  - Dropping the enable returns the cache to idle on the next edge.
- States: IDLE, GRANT, CAPTURE, RELEASE.
- IDLE:
  - If any req_valid is set, select a winner by round-robin, searching from rr_ptr upward with wrap-around.
  - Latch the winner's write, through, addr and wdata into internal registers.
  - Go to GRANT and set rr_ptr = winner+1 mod NUM_REQ.
- GRANT:
  - Drive exactly one of w_en/r_en from the latched write bit, the matching through select, and addr/data_store from the latches.
  - Requester-side changes are ignored after latching.
  - The watchdog counts up each cycle.
  - On done, go to CAPTURE.
  - If the count reaches TIMEOUT-1 without done, set timeout_err and go to RELEASE with req_rdata = 0.
- CAPTURE (one cycle):
  - Enables stay high.
  - At the end of the cycle, register data_load into req_rdata for loads; stores leave req_rdata = 0.
- RELEASE (one cycle):
  - Enables and selects are 0.
  - req_ack[winner] = 1 and req_rdata is valid.
  - The watchdog count clears.
  - Arbitration runs as in IDLE, but the just-acked requester is masked, because its valid may still be high this cycle.
  - If another requester is valid, go directly to GRANT; the enable rises the cycle after RELEASE, when the cache is back in WAIT. Otherwise go to IDLE.
- Latency, uncontended:
  - Valid seen in IDLE at cycle t gives an enable at t+1.
  - If done rises at t+1+k, CAPTURE is at t+2+k and RELEASE/ack is at t+3+k.
- Round-robin properties:
  - No requester is granted twice while another continuously valid requester waits.
  - With all valid from reset, the grant order is 0,1,2,3,0,...
- Boundaries:
  - A requester dropping req_valid before ack is illegal. The latched transaction still completes and is acked.
  - done while in IDLE or RELEASE is ignored.
  - NUM_REQ=1: the mask in RELEASE forces IDLE between transactions.
  - req_write and req_through are never mixed between requesters.
- busy: high in GRANT and CAPTURE only.

Test Plan:
- Single store: req0 writes addr 0x10, data 0xDEADBEEF, cache done after 3 cycles → w_en high 3 cycles plus CAPTURE; req_ack[0] pulses once; r_en never high.
- Single load: req2 reads addr 0x10, cache returns 0xDEADBEEF the cycle after done → req_rdata=0xDEADBEEF with req_ack[2]; latency = done delay + 3.
- Contention: all 4 valid from reset, loads to distinct addrs → acks in order 0,1,2,3,0; one dead cycle (RELEASE) between enables; never two enables high.
- Stale-valid: only req1 valid and it keeps valid high one cycle after its ack → no regrant (IDLE follows); regranted only after a fresh assertion.
- Through path: req3 read with req_through=1 → r_en=1, read_through=1, write_through=0; addr stable while req_addr[3] changes mid-transaction.
- Watchdog: done never asserted → timeout_err=1 at cycle TIMEOUT after grant; req_ack pulses with rdata 0; async reset mid-GRANT → enables 0 immediately and timeout_err cleared.
